dmem_arbiter: RTL and testbench



---
 rtl/dmem_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/dmem_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: M-stage opcodes,
// arbiter state encoding and peripheral port indices.
package dmem_pkg;

    localparam logic [4:0] LW = 5'b01000;
    localparam logic [4:0] SW = 5'b00111;

    localparam logic PORT_VGA  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; after a grant the pointer moves to the other
// port so a continuously requesting port cannot lock out its neighbour.
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (ptr_q == PORT_HOST) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
            if (gnt[0]) begin
                ptr_d = PORT_HOST;
            end else if (gnt[1]) begin
                ptr_d = PORT_VGA;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= PORT_VGA;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU memory stage and two peripherals
// (VGA reader, host loader); a starvation counter forces a one-cycle CPU freeze.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_active,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_wren,
    output logic              cpu_hold,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    arb_state_e state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       rd_valid_q, rd_valid_d;
    logic       rd_port_q, rd_port_d;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       cpu_owns;
    logic       any_req;
    logic       any_gnt;
    logic       gnt_we;

    assign req      = {p1_req, p0_req};
    assign any_req  = |req;
    assign cpu_owns = (state_q == RUN) && cpu_active;

    rr_arbiter2 u_rr (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .enable (!cpu_owns),
        .gnt    (gnt)
    );

    assign any_gnt   = |gnt;
    assign gnt_we    = gnt[1] ? p1_we : p0_we;
    assign p0_gnt    = gnt[0];
    assign p1_gnt    = gnt[1];
    assign cpu_hold  = (state_q == HOLD);
    assign p0_rvalid = rd_valid_q && (rd_port_q == PORT_VGA);
    assign p1_rvalid = rd_valid_q && (rd_port_q == PORT_HOST);
    assign p_rdata   = rd_valid_q ? mem_q : '0;

    // Idle cycles keep the CPU address on the RAM but never its write enable.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wren  = 1'b0;
        if (cpu_owns) begin
            mem_wren = cpu_wren;
        end else if (gnt[0]) begin
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
            mem_wren  = p0_we;
        end else if (gnt[1]) begin
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
            mem_wren  = p1_we;
        end
    end

    always_comb begin
        state_d = RUN;
        if ((state_q == RUN) && any_req && !any_gnt && (wait_cnt_q == LIMIT - 8'd1)) begin
            state_d = HOLD;
        end

        wait_cnt_d = wait_cnt_q;
        if (!any_req || any_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < LIMIT) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        rd_valid_d = any_gnt && !gnt_we;
        rd_port_d  = gnt[1] ? PORT_HOST : PORT_VGA;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            rd_valid_q <= 1'b0;
            rd_port_q  <= PORT_VGA;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_port_q  <= rd_port_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (starvation limits 8 and 1) share the
// stimulus, each with its own RAM, checked every cycle against a reference model.
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic          cpu_active = 1'b0;
    logic [AW-1:0] cpu_addr   = '0;
    logic [DW-1:0] cpu_wdata  = '0;
    logic          cpu_wren   = 1'b0;
    logic          p0_req = 1'b0, p0_we = 1'b0;
    logic [AW-1:0] p0_addr  = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p1_addr  = '0;
    logic [DW-1:0] p1_wdata = '0;

    logic [1:0]          hold_o, g0_o, g1_o, rv0_o, rv1_o, mwren;
    logic [1:0][DW-1:0]  rdata_o, mwdata, mq;
    logic [1:0][AW-1:0]  maddr;

    logic [DW-1:0] ram [2][4096];

    int checks = 0;
    int errors = 0;

    // reference model state (per instance) and next-state computed each negedge
    bit            m_hold [2];
    bit            m_ptr  [2];
    int            m_wait [2];
    bit            m_rv   [2];
    bit            m_rvp  [2];
    logic [DW-1:0] m_rvd  [2];
    logic [DW-1:0] shadow [2][4096];

    int            e_win    [2];
    bit            e_hold_n [2];
    int            e_wait_n [2];
    bit            e_ptr_n  [2];
    bit            e_rv_n   [2];
    bit            e_rvp_n  [2];
    logic [DW-1:0] e_rvd_n  [2];
    bit            e_wr_n   [2];
    logic [AW-1:0] e_wa_n   [2];
    logic [DW-1:0] e_wd_n   [2];

    bit got [2][2];

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(8)) dut (
        .clock(clock), .reset(reset),
        .cpu_active(cpu_active), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wren(cpu_wren), .cpu_hold(hold_o[0]),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(g0_o[0]), .p0_rvalid(rv0_o[0]),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(g1_o[0]), .p1_rvalid(rv1_o[0]),
        .p_rdata(rdata_o[0]), .mem_addr(maddr[0]), .mem_wdata(mwdata[0]),
        .mem_wren(mwren[0]), .mem_q(mq[0])
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(1)) dut_l1 (
        .clock(clock), .reset(reset),
        .cpu_active(cpu_active), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wren(cpu_wren), .cpu_hold(hold_o[1]),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(g0_o[1]), .p0_rvalid(rv0_o[1]),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(g1_o[1]), .p1_rvalid(rv1_o[1]),
        .p_rdata(rdata_o[1]), .mem_addr(maddr[1]), .mem_wdata(mwdata[1]),
        .mem_wren(mwren[1]), .mem_q(mq[1])
    );

    function automatic int lim(input int k);
        return (k == 0) ? 8 : 1;
    endfunction

    function automatic logic [DW-1:0] init_word(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // RAM fixture per instance: registered read, write on the same edge
    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mq[k] <= '0;
                for (int i = 0; i < 4096; i++) ram[k][i] <= init_word(i);
            end else begin
                mq[k] <= ram[k][maddr[k]];
                if (mwren[k]) ram[k][maddr[k]] <= mwdata[k];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compute owner from the rules, compare every output, derive next model state
    task automatic compareModel();
        for (int k = 0; k < 2; k++) begin
            bit            cpu_own, anyr, granted;
            int            win;
            logic [AW-1:0] ea, pa;
            logic [DW-1:0] ed;
            logic          ew, pwe;
            cpu_own = !m_hold[k] && cpu_active;
            win = -1;
            if (!cpu_own) begin
                if (p0_req && p1_req) win = m_ptr[k] ? 1 : 0;
                else if (p0_req)      win = 0;
                else if (p1_req)      win = 1;
            end
            ea = cpu_addr; ed = cpu_wdata; ew = 1'b0;
            pa = p0_addr;  pwe = p0_we;
            if (win == 1) begin pa = p1_addr; pwe = p1_we; end
            if (cpu_own) begin
                ew = cpu_wren;
            end else if (win == 0) begin
                ea = p0_addr; ed = p0_wdata; ew = p0_we;
            end else if (win == 1) begin
                ea = p1_addr; ed = p1_wdata; ew = p1_we;
            end

            checkOutput($sformatf("i%0d p0_gnt", k), 64'(g0_o[k]), 64'(win == 0));
            checkOutput($sformatf("i%0d p1_gnt", k), 64'(g1_o[k]), 64'(win == 1));
            checkOutput($sformatf("i%0d cpu_hold", k), 64'(hold_o[k]), 64'(m_hold[k]));
            checkOutput($sformatf("i%0d mem_wren", k), 64'(mwren[k]), 64'(ew));
            checkOutput($sformatf("i%0d mem_addr", k), 64'(maddr[k]), 64'(ea));
            if (ew) checkOutput($sformatf("i%0d mem_wdata", k), 64'(mwdata[k]), 64'(ed));
            checkOutput($sformatf("i%0d p0_rvalid", k), 64'(rv0_o[k]), 64'(m_rv[k] && !m_rvp[k]));
            checkOutput($sformatf("i%0d p1_rvalid", k), 64'(rv1_o[k]), 64'(m_rv[k] && m_rvp[k]));
            checkOutput($sformatf("i%0d p_rdata", k), 64'(rdata_o[k]), m_rv[k] ? 64'(m_rvd[k]) : 64'd0);

            anyr    = p0_req || p1_req;
            granted = (win >= 0);
            e_win[k]    = win;
            e_hold_n[k] = !m_hold[k] && anyr && !granted && (m_wait[k] + 1 == lim(k));
            if (!anyr || granted)            e_wait_n[k] = 0;
            else if (m_wait[k] + 1 > lim(k)) e_wait_n[k] = lim(k);
            else                             e_wait_n[k] = m_wait[k] + 1;
            e_ptr_n[k] = granted ? (win == 0) : m_ptr[k];
            e_rv_n[k]  = granted && !pwe;
            e_rvp_n[k] = (win == 1);
            e_rvd_n[k] = shadow[k][pa];
            e_wr_n[k]  = ew;
            e_wa_n[k]  = ea;
            e_wd_n[k]  = ed;
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            compareModel();
        end
    end

    always @(posedge clock or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_hold[k] <= 1'b0;
                m_ptr[k]  <= 1'b0;
                m_wait[k] <= 0;
                m_rv[k]   <= 1'b0;
                m_rvp[k]  <= 1'b0;
                m_rvd[k]  <= '0;
                for (int i = 0; i < 4096; i++) shadow[k][i] <= init_word(i);
            end else begin
                m_hold[k] <= e_hold_n[k];
                m_ptr[k]  <= e_ptr_n[k];
                m_wait[k] <= e_wait_n[k];
                m_rv[k]   <= e_rv_n[k];
                m_rvp[k]  <= e_rvp_n[k];
                m_rvd[k]  <= e_rvd_n[k];
                if (e_wr_n[k]) shadow[k][e_wa_n[k]] <= e_wd_n[k];
            end
        end
    end

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clearInputs();
        cpu_active = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wren = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    // Random traffic; a request keeps its fields until both instances granted it
    task automatic applyStimulus(input int cycles, input int cpu_pct, input int req_pct);
        repeat (cycles) begin
            nextCycle();
            for (int k = 0; k < 2; k++) begin
                if (e_win[k] == 0) got[k][0] = 1'b1;
                if (e_win[k] == 1) got[k][1] = 1'b1;
            end
            cpu_active = ($urandom_range(0, 99) < cpu_pct);
            cpu_addr   = AW'($urandom_range(0, 63));
            cpu_wdata  = $urandom;
            cpu_wren   = 1'($urandom_range(0, 1));
            if (!p0_req || (got[0][0] && got[1][0])) begin
                p0_req   = ($urandom_range(0, 99) < req_pct);
                p0_we    = 1'($urandom_range(0, 1));
                p0_addr  = AW'($urandom_range(0, 63));
                p0_wdata = $urandom;
                got[0][0] = 1'b0; got[1][0] = 1'b0;
            end
            if (!p1_req || (got[0][1] && got[1][1])) begin
                p1_req   = ($urandom_range(0, 99) < req_pct);
                p1_we    = 1'($urandom_range(0, 1));
                p1_addr  = AW'($urandom_range(0, 63));
                p1_wdata = $urandom;
                got[0][1] = 1'b0; got[1][1] = 1'b0;
            end
        end
    endtask

    initial begin
        int gnt_at, hold_at, hold_cnt0, hold_cnt1, consec;
        bit prev_h1;

        // reset with all inputs low: every output is zero
        clearInputs();
        reset = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("rst i%0d cpu_hold", k), 64'(hold_o[k]), 64'd0);
            checkOutput($sformatf("rst i%0d p0_gnt", k), 64'(g0_o[k]), 64'd0);
            checkOutput($sformatf("rst i%0d p1_gnt", k), 64'(g1_o[k]), 64'd0);
            checkOutput($sformatf("rst i%0d p0_rvalid", k), 64'(rv0_o[k]), 64'd0);
            checkOutput($sformatf("rst i%0d p1_rvalid", k), 64'(rv1_o[k]), 64'd0);
            checkOutput($sformatf("rst i%0d p_rdata", k), 64'(rdata_o[k]), 64'd0);
            checkOutput($sformatf("rst i%0d mem_wren", k), 64'(mwren[k]), 64'd0);
            checkOutput($sformatf("rst i%0d mem_addr", k), 64'(maddr[k]), 64'd0);
        end
        nextCycle();
        reset = 1'b0;

        // p0 read of 0x010 while the CPU is idle
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 12'h010;
        @(negedge clock);
        checkOutput("t2 p0_gnt", 64'(g0_o[0]), 64'd1);
        checkOutput("t2 mem_addr", 64'(maddr[0]), 64'h010);
        nextCycle();
        p0_req = 1'b0;
        @(negedge clock);
        checkOutput("t2 p0_rvalid", 64'(rv0_o[0]), 64'd1);
        checkOutput("t2 p_rdata", 64'(rdata_o[0]), 64'(init_word(12'h010)));

        // CPU store beats a pending p1 write, p1 gets the next idle cycle
        nextCycle();
        cpu_active = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'h020; cpu_wdata = 32'hDEADBEEF;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 12'h030; p1_wdata = 32'h12345678;
        @(negedge clock);
        checkOutput("t3 mem_wren", 64'(mwren[0]), 64'd1);
        checkOutput("t3 mem_addr", 64'(maddr[0]), 64'h020);
        checkOutput("t3 mem_wdata", 64'(mwdata[0]), 64'hDEADBEEF);
        checkOutput("t3 p1_gnt busy", 64'(g1_o[0]), 64'd0);
        nextCycle();
        cpu_active = 1'b0; cpu_wren = 1'b0;
        @(negedge clock);
        checkOutput("t3 p1_gnt idle", 64'(g1_o[0]), 64'd1);
        checkOutput("t3 p1 mem_addr", 64'(maddr[0]), 64'h030);
        nextCycle();
        p1_req = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 12'h020;
        @(negedge clock);
        checkOutput("t3 readback gnt", 64'(g0_o[0]), 64'd1);
        nextCycle();
        p0_req = 1'b0;
        @(negedge clock);
        checkOutput("t3 readback data", 64'(rdata_o[0]), 64'hDEADBEEF);

        // both ports every cycle from a fresh pointer: p0,p1,p0,p1
        nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 12'h040;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 12'h050;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput($sformatf("t4 p0_gnt %0d", i), 64'(g0_o[0]), 64'(i % 2 == 0));
            checkOutput($sformatf("t4 p1_gnt %0d", i), 64'(g1_o[0]), 64'(i % 2 == 1));
            if (i > 0) begin
                checkOutput($sformatf("t4 p0_rvalid %0d", i), 64'(rv0_o[0]), 64'(i % 2 == 1));
                checkOutput($sformatf("t4 p1_rvalid %0d", i), 64'(rv1_o[0]), 64'(i % 2 == 0));
                checkOutput($sformatf("t4 p_rdata %0d", i), 64'(rdata_o[0]),
                            64'(init_word((i % 2 == 1) ? 12'h040 : 12'h050)));
            end
            nextCycle();
        end
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clock);
        checkOutput("t4 last p1_rvalid", 64'(rv1_o[0]), 64'd1);

        // starvation under a permanently busy CPU
        nextCycle();
        clearInputs();
        nextCycle();
        cpu_active = 1'b1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 12'h060;
        gnt_at = -1; hold_at = 0; hold_cnt0 = 0; hold_cnt1 = 0; consec = 0; prev_h1 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (g0_o[0] && gnt_at < 0) begin
                gnt_at  = c;
                hold_at = int'(hold_o[0]);
            end
            hold_cnt0 += int'(hold_o[0]);
            if (c < 8) hold_cnt1 += int'(hold_o[1]);
            if (hold_o[1] && prev_h1) consec++;
            prev_h1 = hold_o[1];
            nextCycle();
            if (gnt_at >= 0) p0_req = 1'b0;
        end
        checkOutput("t5 gnt cycle", 64'(gnt_at), 64'd8);
        checkOutput("t5 hold at gnt", 64'(hold_at), 64'd1);
        checkOutput("t5 hold count", 64'(hold_cnt0), 64'd1);
        checkOutput("t5 L1 hold count", 64'(hold_cnt1), 64'd4);
        checkOutput("t5 L1 consecutive holds", 64'(consec), 64'd0);

        // reset right after a p1 read grant swallows the read return
        clearInputs();
        nextCycle();
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 12'h070;
        @(negedge clock);
        checkOutput("t6 p1_gnt", 64'(g1_o[0]), 64'd1);
        nextCycle();
        reset = 1'b1;
        p1_req = 1'b0; p1_addr = '0;
        #1;
        checkOutput("t6 p1_rvalid in reset", 64'(rv1_o[0]), 64'd0);
        checkOutput("t6 p_rdata in reset", 64'(rdata_o[0]), 64'd0);
        checkOutput("t6 cpu_hold in reset", 64'(hold_o[0]), 64'd0);
        checkOutput("t6 mem_wren in reset", 64'(mwren[0]), 64'd0);
        nextCycle();
        reset = 1'b0;
        @(negedge clock);
        checkOutput("t6 p1_rvalid after", 64'(rv1_o[0]), 64'd0);

        // randomized traffic at several CPU loads
        applyStimulus(400, 50, 60);
        applyStimulus(300, 90, 80);
        applyStimulus(300, 10, 90);
        nextCycle();
        clearInputs();
        repeat (3) nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
